// File: rtl/quad_decoder_if.sv
// Encoder-path bus between the debounced quadrature pins and the UI logic.
// The driver side supplies A/B plus clear controls; the decoder returns position/steps/error.
interface quad_decoder_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    a;
  logic                    b;
  logic                    clear;
  logic                    err_clr;
  logic signed [WIDTH-1:0] position;
  logic                    step_up;
  logic                    step_dn;
  logic                    err;

  modport master (
    output a, b, clear, err_clr,
    input  position, step_up, step_dn, err
  );

  modport slave (
    input  a, b, clear, err_clr,
    output position, step_up, step_dn, err
  );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: turns debounced A/B into a signed detent count, step pulses and a
// sticky illegal-transition flag. Inputs are already synchronous to clk.
module quad_decoder #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DETENT   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  quad_decoder_if.slave bus
);

  typedef enum logic [1:0] {StInit, StPrime, StRun} state_e;

  localparam logic signed [2:0]       SubMax = 3'(DETENT - 1);
  localparam logic signed [WIDTH-1:0] PosMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] PosMin = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] PosOne = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q;
  logic [1:0]              ab_q, ab_qq;
  logic signed [2:0]       sub_q, sub_d;
  logic signed [WIDTH-1:0] pos_q, pos_d;
  logic                    up_q, up_d;
  logic                    dn_q, dn_d;
  logic                    err_q, err_d;
  logic                    inc, dec, illegal;

  // Gray-code decode of the previous -> current sample; only trusted once both are real samples.
  always_comb begin
    inc     = 1'b0;
    dec     = 1'b0;
    illegal = 1'b0;
    if (state_q == StRun) begin
      case ({ab_qq, ab_q})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: inc     = 1'b1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: dec     = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    sub_d = sub_q;
    pos_d = pos_q;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    // A simultaneous illegal transition beats err_clr.
    err_d = (err_q & ~bus.err_clr) | illegal;
    if (bus.clear) begin
      sub_d = '0;
      pos_d = '0;
    end else if (inc) begin
      if (sub_q == SubMax) begin
        sub_d = '0;
        up_d  = 1'b1;
        if (!(SATURATE && (pos_q == PosMax))) begin
          pos_d = pos_q + PosOne;
        end
      end else begin
        sub_d = sub_q + 3'sd1;
      end
    end else if (dec) begin
      if (sub_q == -SubMax) begin
        sub_d = '0;
        dn_d  = 1'b1;
        if (!(SATURATE && (pos_q == PosMin))) begin
          pos_d = pos_q - PosOne;
        end
      end else begin
        sub_d = sub_q - 3'sd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      ab_q    <= 2'b00;
      ab_qq   <= 2'b00;
      sub_q   <= '0;
      pos_q   <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ab_q  <= {bus.a, bus.b};
      ab_qq <= ab_q;
      sub_q <= sub_d;
      pos_q <= pos_d;
      up_q  <= up_d;
      dn_q  <= dn_d;
      err_q <= err_d;
      case (state_q)
        StInit:  state_q <= StPrime;
        StPrime: state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.position = pos_q;
  assign bus.step_up  = up_q;
  assign bus.step_dn  = dn_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: four parameterisations share one stimulus stream and are compared
// every cycle against a quarter-step arithmetic model, plus directed scenario checks.
module tb_quad_decoder;

  localparam int NInst = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic clear = 1'b0;
  logic err_clr = 1'b0;

  logic signed [31:0] dpos [NInst];
  logic               dup  [NInst];
  logic               ddn  [NInst];
  logic               derr [NInst];

  int p_w [NInst] = '{16, 4, 4, 8};
  int p_d [NInst] = '{4, 4, 4, 2};
  bit p_s [NInst] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic [1:0] cw_seq    [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] ccw_seq   [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] gray_from [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  int n_checks = 0;
  int n_errors = 0;
  int n_up [NInst] = '{0, 0, 0, 0};
  int n_dn [NInst] = '{0, 0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NInst; g++) begin : g_inst
    localparam int unsigned GW = (g == 0) ? 16 : ((g == 3) ? 8 : 4);
    localparam int unsigned GD = (g == 3) ? 2 : 4;
    localparam bit          GS = (g == 1) || (g == 3);

    quad_decoder_if #(.WIDTH(GW)) bus ();

    assign bus.a       = a;
    assign bus.b       = b;
    assign bus.clear   = clear;
    assign bus.err_clr = err_clr;

    quad_decoder #(
      .WIDTH   (GW),
      .DETENT  (GD),
      .SATURATE(GS)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    assign dpos[g] = 32'(bus.position);
    assign dup[g]  = bus.step_up;
    assign ddn[g]  = bus.step_dn;
    assign derr[g] = bus.err;
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_pos [NInst];
  int         m_sub [NInst];
  bit         m_up  [NInst];
  bit         m_dn  [NInst];
  bit         m_err [NInst];
  int         m_k;
  logic [1:0] m_last1, m_last2;

  function automatic int gray_idx(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int bump(input int pos, input int w, input bit sat, input int dir);
    int mx;
    int mn;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    if (dir > 0) begin
      if (pos == mx) return sat ? mx : mn;
      return pos + 1;
    end
    if (pos == mn) return sat ? mn : mx;
    return pos - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NInst; i++) begin
      m_pos[i] = 0;
      m_sub[i] = 0;
      m_up[i]  = 1'b0;
      m_dn[i]  = 1'b0;
      m_err[i] = 1'b0;
    end
    m_k     = 0;
    m_last1 = 2'b00;
    m_last2 = 2'b00;
  endtask

  task automatic model_step();
    int dir;
    int dq;
    bit ill;
    dir = 0;
    ill = 1'b0;
    // A transition is only trusted once two real samples have been taken since reset.
    if (m_k >= 2) begin
      dq = (gray_idx(m_last1) - gray_idx(m_last2) + 4) % 4;
      if (dq == 1) dir = 1;
      else if (dq == 3) dir = -1;
      else if (dq == 2) ill = 1'b1;
    end
    for (int i = 0; i < NInst; i++) begin
      m_up[i] = 1'b0;
      m_dn[i] = 1'b0;
      if (err_clr) m_err[i] = 1'b0;
      if (ill) m_err[i] = 1'b1;
      if (clear) begin
        m_pos[i] = 0;
        m_sub[i] = 0;
      end else if (dir != 0) begin
        m_sub[i] += dir;
        if (m_sub[i] == p_d[i]) begin
          m_sub[i] = 0;
          m_up[i]  = 1'b1;
          m_pos[i] = bump(m_pos[i], p_w[i], p_s[i], 1);
        end else if (m_sub[i] == -p_d[i]) begin
          m_sub[i] = 0;
          m_dn[i]  = 1'b1;
          m_pos[i] = bump(m_pos[i], p_w[i], p_s[i], -1);
        end
      end
    end
    m_last2 = m_last1;
    m_last1 = {a, b};
    if (m_k < 2) m_k++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < NInst; i++) begin
        check($sformatf("pos%0d", i), dpos[i], m_pos[i]);
        check($sformatf("up%0d", i), 32'(dup[i]), 32'(m_up[i]));
        check($sformatf("dn%0d", i), 32'(ddn[i]), 32'(m_dn[i]));
        check($sformatf("err%0d", i), 32'(derr[i]), 32'(m_err[i]));
        if (dup[i] === 1'b1) n_up[i]++;
        if (ddn[i] === 1'b1) n_dn[i]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_ab(input logic [1:0] v, input int hold);
    {a, b} = v;
    repeat (hold) @(negedge clk);
  endtask

  task automatic cw_detents(input int n, input int hold);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) drive_ab(cw_seq[j], hold);
  endtask

  task automatic ccw_detents(input int n, input int hold);
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) drive_ab(ccw_seq[j], hold);
  endtask

  int base_up0;
  int base_up1;

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("rst_pos", dpos[0], 0);
    check("rst_up", 32'(dup[0]), 0);
    check("rst_dn", 32'(ddn[0]), 0);
    check("rst_err", 32'(derr[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // One full CW detent.
    cw_detents(1, 4);
    #2;
    check("cw_pos", dpos[0], 1);
    check("cw_pulses", n_up[0], 1);
    check("cw_pos_d2", dpos[3], 2);

    // Two CCW detents.
    ccw_detents(2, 4);
    #2;
    check("ccw_pos", dpos[0], -1);
    check("ccw_pulses", n_dn[0], 2);

    // Reversal mid-detent.
    drive_ab(2'b10, 4);
    drive_ab(2'b11, 4);
    drive_ab(2'b10, 4);
    drive_ab(2'b00, 4);
    #2;
    check("rev_pos", dpos[0], -1);
    check("rev_up", n_up[0], 1);
    check("rev_dn", n_dn[0], 2);

    // Illegal jump and err_clr interplay.
    drive_ab(2'b11, 3);
    #2;
    check("ill_err", 32'(derr[0]), 1);
    check("ill_pos", dpos[0], -1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    #2;
    check("errclr", 32'(derr[0]), 0);
    drive_ab(2'b10, 3);
    {a, b} = 2'b01;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #2;
    check("err_set_wins", 32'(derr[0]), 1);
    drive_ab(2'b00, 3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;

    // Clamp vs wrap at WIDTH=4.
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #2;
    check("clear_pos", dpos[0], 0);
    cw_detents(7, 1);
    repeat (2) @(negedge clk);
    #2;
    check("pre_sat", dpos[1], 7);
    check("pre_wrap", dpos[2], 7);
    base_up1 = n_up[1];
    cw_detents(1, 1);
    repeat (2) @(negedge clk);
    #2;
    check("sat_pos", dpos[1], 7);
    check("sat_pulse", n_up[1] - base_up1, 1);
    check("wrap_pos", dpos[2], -8);
    check("w16_pos", dpos[0], 8);

    // clear coincident with a completing detent.
    base_up0 = n_up[0];
    drive_ab(2'b10, 1);
    drive_ab(2'b11, 1);
    drive_ab(2'b01, 1);
    {a, b} = 2'b00;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("clr_det_pos", dpos[0], 0);
    check("clr_det_nopulse", n_up[0] - base_up0, 0);
    cw_detents(1, 2);
    #2;
    check("post_clr_pos", dpos[0], 1);
    check("post_clr_pulse", n_up[0] - base_up0, 1);

    // Reset mid-detent with A/B parked at 11.
    drive_ab(2'b10, 2);
    drive_ab(2'b11, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pos", dpos[0], 0);
    check("mid_rst_up", 32'(dup[0]), 0);
    check("mid_rst_err", 32'(derr[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_up0 = n_up[0];
    repeat (5) @(negedge clk);
    #2;
    check("hold11_pos", dpos[0], 0);
    check("hold11_nopulse", n_up[0] - base_up0, 0);
    drive_ab(2'b01, 2);
    drive_ab(2'b00, 2);
    drive_ab(2'b10, 2);
    drive_ab(2'b11, 2);
    #2;
    check("post_rst_pos", dpos[0], 1);

    // Randomized traffic against the model.
    for (int it = 0; it < 1500; it++) begin
      int r;
      int hold;
      int gi;
      r    = $urandom_range(0, 199);
      hold = $urandom_range(1, 3);
      gi   = gray_idx({a, b});
      if (r < 140) begin
        gi = (gi + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4;
        drive_ab(gray_from[gi], hold);
      end else if (r < 160) begin
        repeat (hold) @(negedge clk);
      end else if (r < 172) begin
        drive_ab(gray_from[(gi + 2) % 4], hold);
      end else if (r < 184) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end else if (r < 196) begin
        err_clr = 1'b1;
        if ($urandom_range(0, 1) == 1) {a, b} = gray_from[(gi + 2) % 4];
        @(negedge clk);
        err_clr = 1'b0;
      end else begin
        #3;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (4) @(negedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
